// File: rtl/complex_pkg.sv
// Shared mode encodings and the round-half-up helper for the complex arithmetic pipeline.
package complex_pkg;

  // Wide enough for a 2*64+1 bit combine plus one bit of rounding headroom.
  localparam int RS_W = 130;

  localparam logic [1:0] CPLX_MODE_MUL   = 2'd0;
  localparam logic [1:0] CPLX_MODE_CMUL  = 2'd1;
  localparam logic [1:0] CPLX_MODE_POWER = 2'd2;
  localparam logic [1:0] CPLX_MODE_ADD   = 2'd3;

  typedef enum logic [1:0] {
    MUL   = CPLX_MODE_MUL,
    CMUL  = CPLX_MODE_CMUL,
    POWER = CPLX_MODE_POWER,
    ADD   = CPLX_MODE_ADD
  } cplx_mode_e;

  function automatic logic signed [RS_W-1:0] round_shift(input logic signed [RS_W-1:0] value,
                                                          input int unsigned frac);
    logic signed [RS_W-1:0] half;
    half = RS_W'(1) << (frac - 1);
    return (value + half) >>> frac;
  endfunction

endpackage

// File: rtl/cplx_round_sat.sv
// Combinational round-half-up and clamp/wrap of one wide result component.
// Saturation is built only when CPLX_MUL_SAT_EN is defined; otherwise results wrap.
module cplx_round_sat
  import complex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 31,
  parameter int IN_W   = 2*DATA_W+1
) (
  input  logic signed [IN_W-1:0]   value,
  input  logic                     round_en,
  output logic signed [DATA_W-1:0] result,
  output logic                     sat
);

  logic signed [RS_W-1:0] ext;
  logic signed [RS_W-1:0] wide;

`ifdef CPLX_MUL_SAT_EN
  // Representable iff every bit from the DATA_W sign bit upward agrees.
  function automatic logic overflow(input logic signed [RS_W-1:0] v);
    logic [RS_W-DATA_W:0] top;
    top = v[RS_W-1:DATA_W-1];
    return !((&top) || !(|top));
  endfunction

  function automatic logic signed [DATA_W-1:0] clamp(input logic signed [RS_W-1:0] v);
    if (overflow(v))
      return v[RS_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    return v[DATA_W-1:0];
  endfunction

  always_comb begin
    ext    = {{(RS_W-IN_W){value[IN_W-1]}}, value};
    wide   = round_en ? round_shift(ext, FRAC_W) : ext;
    result = clamp(wide);
    sat    = overflow(wide);
  end
`else
  logic unused_hi;

  always_comb begin
    ext       = {{(RS_W-IN_W){value[IN_W-1]}}, value};
    wide      = round_en ? round_shift(ext, FRAC_W) : ext;
    result    = wide[DATA_W-1:0];
    sat       = 1'b0;
    unused_hi = ^wide[RS_W-1:DATA_W];
  end
`endif

endmodule

// File: rtl/cplx_mul_pipe.sv
// Three-stage complex MUL/CMUL/POWER/ADD unit with valid/ready flow control.
// Define CPLX_MUL_SAT_EN for clamping outputs; the default build wraps.
module cplx_mul_pipe
  import complex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 31,
  parameter int USER_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_mode,
  input  logic signed [DATA_W-1:0] in_a_re,
  input  logic signed [DATA_W-1:0] in_a_im,
  input  logic signed [DATA_W-1:0] in_b_re,
  input  logic signed [DATA_W-1:0] in_b_im,
  input  logic [USER_W-1:0]        in_user,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im,
  output logic [USER_W-1:0]        out_user,
  output logic                     out_sat,
  output logic                     sat_sticky
);

  localparam int PW = 2*DATA_W;
  localparam int CW = 2*DATA_W+1;

  logic                     vld_p0_q, vld_p0_d;
  cplx_mode_e               mode_p0_q, mode_p0_d;
  logic signed [DATA_W-1:0] a_re_p0_q, a_re_p0_d, a_im_p0_q, a_im_p0_d;
  logic signed [DATA_W-1:0] b_re_p0_q, b_re_p0_d, b_im_p0_q, b_im_p0_d;
  logic [USER_W-1:0]        user_p0_q, user_p0_d;

  logic                     vld_p1_q, vld_p1_d;
  cplx_mode_e               mode_p1_q, mode_p1_d;
  logic signed [PW-1:0]     rr_p1_q, rr_p1_d, ii_p1_q, ii_p1_d;
  logic signed [PW-1:0]     ri_p1_q, ri_p1_d, ir_p1_q, ir_p1_d;
  logic [USER_W-1:0]        user_p1_q, user_p1_d;

  logic                     vld_p2_q, vld_p2_d;
  logic signed [DATA_W-1:0] re_p2_q, re_p2_d, im_p2_q, im_p2_d;
  logic                     sat_p2_q, sat_p2_d;
  logic [USER_W-1:0]        user_p2_q, user_p2_d;
  logic                     sticky_q, sticky_d;

  logic                     ld_p0, ld_p1, ld_p2;
  logic signed [DATA_W-1:0] op_b_re, op_b_im;
  logic signed [CW-1:0]     re_w, im_w;
  logic                     round_en;
  logic signed [DATA_W-1:0] rs_re, rs_im;
  logic                     sat_re, sat_im;

  // Each stage loads when empty or when its occupant moves on this cycle.
  always_comb begin
    ld_p2 = !vld_p2_q || out_ready;
    ld_p1 = !vld_p1_q || ld_p2;
    ld_p0 = !vld_p0_q || ld_p1;
  end

  assign in_ready = ld_p0;

  // Stage p0: operand capture
  always_comb begin
    vld_p0_d  = vld_p0_q;
    mode_p0_d = mode_p0_q;
    a_re_p0_d = a_re_p0_q;
    a_im_p0_d = a_im_p0_q;
    b_re_p0_d = b_re_p0_q;
    b_im_p0_d = b_im_p0_q;
    user_p0_d = user_p0_q;
    if (ld_p0) vld_p0_d = in_valid;
    if (ld_p0 && in_valid) begin
      mode_p0_d = cplx_mode_e'(in_mode);
      a_re_p0_d = in_a_re;
      a_im_p0_d = in_a_im;
      b_re_p0_d = in_b_re;
      b_im_p0_d = in_b_im;
      user_p0_d = in_user;
    end
  end

  // Stage p1: full-width products, or component sums for ADD
  always_comb begin
    op_b_re   = (mode_p0_q == POWER) ? a_re_p0_q : b_re_p0_q;
    op_b_im   = (mode_p0_q == POWER) ? a_im_p0_q : b_im_p0_q;
    vld_p1_d  = vld_p1_q;
    mode_p1_d = mode_p1_q;
    rr_p1_d   = rr_p1_q;
    ii_p1_d   = ii_p1_q;
    ri_p1_d   = ri_p1_q;
    ir_p1_d   = ir_p1_q;
    user_p1_d = user_p1_q;
    if (ld_p1) vld_p1_d = vld_p0_q;
    if (ld_p1 && vld_p0_q) begin
      mode_p1_d = mode_p0_q;
      user_p1_d = user_p0_q;
      ri_p1_d   = PW'(a_re_p0_q) * PW'(op_b_im);
      ir_p1_d   = PW'(a_im_p0_q) * PW'(op_b_re);
      if (mode_p0_q == ADD) begin
        rr_p1_d = PW'(a_re_p0_q) + PW'(b_re_p0_q);
        ii_p1_d = PW'(a_im_p0_q) + PW'(b_im_p0_q);
      end else begin
        rr_p1_d = PW'(a_re_p0_q) * PW'(op_b_re);
        ii_p1_d = PW'(a_im_p0_q) * PW'(op_b_im);
      end
    end
  end

  // Stage p2: combine, round, saturate/wrap
  always_comb begin
    round_en = (mode_p1_q != ADD);
    case (mode_p1_q)
      CMUL: begin
        re_w = CW'(rr_p1_q) + CW'(ii_p1_q);
        im_w = CW'(ir_p1_q) - CW'(ri_p1_q);
      end
      POWER: begin
        re_w = CW'(rr_p1_q) + CW'(ii_p1_q);
        im_w = '0;
      end
      ADD: begin
        re_w = CW'(rr_p1_q);
        im_w = CW'(ii_p1_q);
      end
      default: begin
        re_w = CW'(rr_p1_q) - CW'(ii_p1_q);
        im_w = CW'(ri_p1_q) + CW'(ir_p1_q);
      end
    endcase
  end

  cplx_round_sat #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .IN_W(CW)) u_rs_re (
    .value    (re_w),
    .round_en (round_en),
    .result   (rs_re),
    .sat      (sat_re)
  );

  cplx_round_sat #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .IN_W(CW)) u_rs_im (
    .value    (im_w),
    .round_en (round_en),
    .result   (rs_im),
    .sat      (sat_im)
  );

  always_comb begin
    vld_p2_d  = vld_p2_q;
    re_p2_d   = re_p2_q;
    im_p2_d   = im_p2_q;
    sat_p2_d  = sat_p2_q;
    user_p2_d = user_p2_q;
    if (ld_p2) vld_p2_d = vld_p1_q;
    if (ld_p2 && vld_p1_q) begin
      re_p2_d   = rs_re;
      im_p2_d   = rs_im;
      sat_p2_d  = sat_re || sat_im;
      user_p2_d = user_p1_q;
    end
    sticky_d = sticky_q || (vld_p2_q && out_ready && sat_p2_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q  <= 1'b0;
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      re_p2_q   <= '0;
      im_p2_q   <= '0;
      sat_p2_q  <= 1'b0;
      user_p2_q <= '0;
      sticky_q  <= 1'b0;
    end else begin
      vld_p0_q  <= vld_p0_d;
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      re_p2_q   <= re_p2_d;
      im_p2_q   <= im_p2_d;
      sat_p2_q  <= sat_p2_d;
      user_p2_q <= user_p2_d;
      sticky_q  <= sticky_d;
    end
  end

  always_ff @(posedge clk) begin
    mode_p0_q <= mode_p0_d;
    a_re_p0_q <= a_re_p0_d;
    a_im_p0_q <= a_im_p0_d;
    b_re_p0_q <= b_re_p0_d;
    b_im_p0_q <= b_im_p0_d;
    user_p0_q <= user_p0_d;
    mode_p1_q <= mode_p1_d;
    rr_p1_q   <= rr_p1_d;
    ii_p1_q   <= ii_p1_d;
    ri_p1_q   <= ri_p1_d;
    ir_p1_q   <= ir_p1_d;
    user_p1_q <= user_p1_d;
  end

  assign out_valid  = vld_p2_q;
  assign out_re     = re_p2_q;
  assign out_im     = im_p2_q;
  assign out_user   = user_p2_q;
  assign out_sat    = sat_p2_q;
  assign sat_sticky = sticky_q;

endmodule

// File: tb/tb_cplx_mul_pipe.sv
// Directed and scoreboarded checks of cplx_mul_pipe at DATA_W=32, FRAC_W=31.
module tb_cplx_mul_pipe;

  localparam int DW = 32;
  localparam int FW = 31;
  localparam int UW = 8;
  localparam int NMAX = 400;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready, out_sat, sat_sticky;
  logic [1:0]    in_mode;
  logic [DW-1:0] in_a_re, in_a_im, in_b_re, in_b_im, out_re, out_im;
  logic [UW-1:0] in_user, out_user;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0]    bm  [NMAX];
  logic [DW-1:0] bar [NMAX];
  logic [DW-1:0] bai [NMAX];
  logic [DW-1:0] bbr [NMAX];
  logic [DW-1:0] bbi [NMAX];
  logic [UW-1:0] bu  [NMAX];
  logic [DW-1:0] er  [NMAX];
  logic [DW-1:0] ei  [NMAX];
  logic          es  [NMAX];

`ifdef CPLX_MUL_SAT_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  cplx_mul_pipe #(.DATA_W(DW), .FRAC_W(FW), .USER_W(UW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .in_a_re    (in_a_re),
    .in_a_im    (in_a_im),
    .in_b_re    (in_b_re),
    .in_b_im    (in_b_im),
    .in_user    (in_user),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_re     (out_re),
    .out_im     (out_im),
    .out_user   (out_user),
    .out_sat    (out_sat),
    .sat_sticky (sat_sticky)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void clip(input logic signed [129:0] x, output logic [31:0] r, output logic s);
    s = 1'b0;
    r = x[31:0];
    if (SAT_ON) begin
      if (x > 130'sd2147483647) begin
        r = 32'h7FFF_FFFF; s = 1'b1;
      end else if (x < -130'sd2147483648) begin
        r = 32'h8000_0000; s = 1'b1;
      end
    end
  endfunction

  function automatic void model(input logic [1:0] m, input logic [31:0] ar, ai, br, bi,
                                output logic [31:0] re, im, output logic sat);
    logic signed [129:0] sar, sai, sbr, sbi, xr, xi, half;
    logic sr, si;
    sar  = 130'(signed'(ar));
    sai  = 130'(signed'(ai));
    sbr  = 130'(signed'(br));
    sbi  = 130'(signed'(bi));
    half = 130'sd1 << (FW - 1);
    case (m)
      2'd0: begin xr = sar*sbr - sai*sbi; xi = sar*sbi + sai*sbr; end
      2'd1: begin xr = sar*sbr + sai*sbi; xi = sai*sbr - sar*sbi; end
      2'd2: begin xr = sar*sar + sai*sai; xi = '0; end
      default: begin xr = sar + sbr; xi = sai + sbi; end
    endcase
    if (m != 2'd3) begin
      xr = (xr + half) >>> FW;
      xi = (xi + half) >>> FW;
    end
    clip(xr, re, sr);
    clip(xi, im, si);
    sat = sr | si;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'(signed'($urandom_range(0, 8)) - 4);
      default: return $urandom;
    endcase
  endfunction

  task automatic fill(input int n, input bit user_from_one);
    for (int k = 0; k < n; k++) begin
      bm[k]  = 2'($urandom_range(0, 3));
      bar[k] = pick();
      bai[k] = pick();
      bbr[k] = pick();
      bbi[k] = pick();
      bu[k]  = user_from_one ? UW'(k + 1) : UW'($urandom);
      model(bm[k], bar[k], bai[k], bbr[k], bbi[k], er[k], ei[k], es[k]);
    end
  endtask

  task automatic single(input string tag, input logic [1:0] m, input logic [31:0] ar, ai, br, bi,
                        input logic [31:0] xre, xim, input logic xsat);
    int cnt;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mode   = m;
    in_a_re   = ar;
    in_a_im   = ai;
    in_b_re   = br;
    in_b_im   = bi;
    in_user   = 8'hA5;
    #1;
    chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, "_latency"}, cnt, 3);
    chk({tag, "_re"}, out_re, xre);
    chk({tag, "_im"}, out_im, xim);
    chk({tag, "_sat"}, out_sat, xsat);
    chk({tag, "_user"}, out_user, 8'hA5);
    @(posedge clk); #1;
  endtask

  // rmode: 0 ready always high, 1 random ready, 2 ready low for 8 cycles then high
  task automatic run_stream(input string tag, input int rmode, input int n);
    int ii, oo, cyc, stall;
    logic acc_in, hold_v;
    logic [31:0] hr, hi;
    logic [UW-1:0] hu;
    ii = 0; oo = 0; cyc = 0; stall = 0; hold_v = 1'b0;
    hr = '0; hi = '0; hu = '0;
    while (oo < n && cyc < 5000) begin
      if (rmode == 2 && cyc == 8) begin
        chk({tag, "_accepted_while_stalled"}, ii, 3);
        chk({tag, "_in_ready_full"}, in_ready, 0);
      end
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 9) < 7);
        default: out_ready = (cyc >= 8);
      endcase
      if (ii < n) begin
        in_valid = 1'b1;
        in_mode  = bm[ii];
        in_a_re  = bar[ii];
        in_a_im  = bai[ii];
        in_b_re  = bbr[ii];
        in_b_im  = bbi[ii];
        in_user  = bu[ii];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (hold_v) begin
        chk({tag, "_hold_valid"}, out_valid, 1);
        chk({tag, "_hold_re"}, out_re, hr);
        chk({tag, "_hold_im"}, out_im, hi);
        chk({tag, "_hold_user"}, out_user, hu);
      end
      acc_in = in_valid && in_ready;
      if (out_valid && out_ready) begin
        if (oo < n) begin
          chk({tag, "_re"}, out_re, er[oo]);
          chk({tag, "_im"}, out_im, ei[oo]);
          chk({tag, "_sat"}, out_sat, es[oo]);
          chk({tag, "_user"}, out_user, bu[oo]);
        end else begin
          chk({tag, "_extra_beat"}, 1, 0);
        end
        oo++;
      end
      hold_v = out_valid && !out_ready;
      hr = out_re;
      hi = out_im;
      hu = out_user;
      if (ii < n && !in_ready) stall++;
      @(posedge clk); #1;
      if (acc_in) ii++;
      cyc++;
    end
    in_valid = 1'b0;
    chk({tag, "_beats_out"}, oo, n);
    if (rmode == 0) begin
      chk({tag, "_full_rate_stalls"}, stall, 0);
      chk({tag, "_full_rate_cycles"}, cyc, n + 3);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_mode = 2'd0; in_user = '0;
    in_a_re = '0; in_a_im = '0; in_b_re = '0; in_b_im = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_re", out_re, 0);
    chk("reset_out_im", out_im, 0);
    chk("reset_out_user", out_user, 0);
    chk("reset_out_sat", out_sat, 0);
    chk("reset_sticky", sat_sticky, 0);

    single("mul_half", 2'd0, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000,
           32'h0000_0000, 32'h4000_0000, 1'b0);
    single("cmul_half", 2'd1, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000,
           32'h4000_0000, 32'h0000_0000, 1'b0);
    single("power_half", 2'd2, 32'h4000_0000, 32'h4000_0000, 32'h1234_5678, 32'h9ABC_DEF0,
           32'h4000_0000, 32'h0000_0000, 1'b0);
    single("round_up", 2'd0, 32'h0000_0001, 32'h0, 32'h4000_0000, 32'h0,
           32'h0000_0001, 32'h0000_0000, 1'b0);
    single("round_neg_half", 2'd0, 32'hFFFF_FFFF, 32'h0, 32'h4000_0000, 32'h0,
           32'h0000_0000, 32'h0000_0000, 1'b0);
    single("add_plain", 2'd3, 32'h0000_0005, 32'hFFFF_FFFD, 32'h0000_0007, 32'h0000_0001,
           32'h0000_000C, 32'hFFFF_FFFE, 1'b0);
    chk("sticky_before_sat", sat_sticky, 0);
    if (SAT_ON) begin
      single("mul_sat", 2'd0, 32'h8000_0000, 32'h0, 32'h8000_0000, 32'h0,
             32'h7FFF_FFFF, 32'h0000_0000, 1'b1);
      chk("sticky_after_sat", sat_sticky, 1);
      single("add_sat", 2'd3, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF,
             32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
    end else begin
      single("mul_wrap", 2'd0, 32'h8000_0000, 32'h0, 32'h8000_0000, 32'h0,
             32'h8000_0000, 32'h0000_0000, 1'b0);
      chk("sticky_after_wrap", sat_sticky, 0);
      single("add_wrap", 2'd3, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF,
             32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    end

    fill(5, 1'b1);
    run_stream("backpressure", 2, 5);
    fill(20, 1'b0);
    run_stream("full_rate", 0, 20);
    fill(NMAX, 1'b0);
    run_stream("random", 1, NMAX);

    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_mode = 2'd0; in_user = UW'(k + 8'h40);
      in_a_re = 32'h8000_0000; in_a_im = '0; in_b_re = 32'h8000_0000; in_b_im = '0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_sticky", sat_sticky, 0);
    chk("flush_out_sat", out_sat, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 1);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    chk("flush_no_stale", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
